guess_game_n: RTL and testbench
===============================

Name: guess_game_n

Overview:
- Parametrised successor to the four-position LED guessing game.
- A one-hot "target" LED walks across N positions, advancing on each `en` strobe. The player presses the button matching the lit LED.
- An exact match is a win and any other press is a loss. The block counts wins, win streak and misses, and locks into a game-over state after a configurable number of misses.
- Sits between the button synchroniser/tick divider and the board LEDs and seven-segment score display.

Parameters:
- N, 4, number of LED/button positions (2..16).
- SCORE_W, 4, width of score and streak counters.
- MAX_MISS, 3, number of losses that ends the game (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  single-cycle tick strobe; all state evaluation happens only on clk edges with en=1.
- dir  in  1  walk direction: 0 = toward MSB (bit0→bit1→…→bit N-1→bit0), 1 = toward LSB.
- in  in  N  synchronised button levels.
- y  out  N  one-hot target LED, registered.
- win  out  1  registered, high while in WIN.
- lose  out  1  registered, high while in LOSE.
- over  out  1  registered, high while in OVER.
- score  out  SCORE_W  total wins, saturating.
- streak  out  SCORE_W  consecutive wins since last loss, saturating.
- misses  out  4  total losses, saturating at MAX_MISS.

Behaviour:
- Reset values (asynchronous assertion, takes priority over everything):
  - state=PLAY, y=1 (bit0).
  - win=0, lose=0, over=0.
  - score=0, streak=0, misses=0.
- No state or output changes on cycles with en=0. All outputs are registered and update on the same edge as the state change (1-cycle latency from the en edge).
- PLAY, on en:
  - in==0: y advances one position in direction `dir`, wrapping N-1↔0. `dir` is sampled at each advance; a change mid-game affects only the next advance.
  - in==y (exactly one bit, matching): go to WIN.
    - score += 1, saturating at 2^SCORE_W-1.
    - streak += 1, saturating.
    - y holds.
  - Any other nonzero in (wrong bit, or multiple bits even if the correct one is included): miss counts as misses += 1.
    - streak=0.
    - If the new misses == MAX_MISS, go to OVER; otherwise go to LOSE.
    - y holds.
- WIN / LOSE, on en:
  - in==0 (all released): go to PLAY with y reset to bit0.
  - Otherwise stay. Held buttons never re-score.
- OVER:
  - Terminal; only rst exits.
  - y holds its last value; over=1; counters frozen.
  - `in` and `en` are ignored.
- Output flags are mutually exclusive: at most one of win/lose/over is high in any cycle.
- Reset asserted mid-game (including mid-WIN/LOSE): immediate return to reset values, no partial counter update.
- Illegal state encodings recover to PLAY with y=1 on the next en.
- Counter widths: misses is 4 bits and never exceeds MAX_MISS.

Optional Feature:
- Macro: GUESS_LFSR_EN.
- Defined:
  - An 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'h01 at reset) steps every clk, independent of en.
  - On each PLAY advance, the new position index = (pos + 1 + (lfsr % (N-1))) % N. The target never repeats the same position on consecutive advances.
  - `dir` is ignored.
  - Reset, WIN/LOSE return and all counters are unchanged.
- Undefined:
  - Deterministic rotation per `dir` as above; no LFSR logic is synthesised.

Test Plan:
- Walk and wrap: N=4, rst then en×5 with in=0, dir=0 → y=0001,0010,0100,1000,0001,0010; en×2 with dir=1 → y=0001,1000.
- Correct press: y=0100, in=0100 on en → win=1, score=1, streak=1. Hold in for 3 ens → stays WIN, score=1. Release, en → PLAY, y=0001, win=0.
- Wrong and multi-press: y=0010, in=0011 on en → lose=1, misses=1, streak=0. Release, en → PLAY, y=0001.
- Game over: MAX_MISS=3, three wrong presses with releases between → third gives over=1, misses=3. Further en/in activity changes nothing. Assert rst → y=0001, all counters 0.
- Saturation: SCORE_W=2, five wins → score=3, streak=3. One loss → streak=0, score=3.
- Async reset with en=0: assert rst mid-WIN with no clk edge → win=0, y=0001 immediately. With GUESS_LFSR_EN, 20 advances → no two consecutive y values are equal.

Source files
------------

// File: rtl/guess_game_n_if.sv
// guess_game_n_if: control, input and display bundle for the guessing-game core.
//   master : drives en/dir/in and observes the game outputs (bench or board glue)
//   slave  : the game core itself
//   en     : single-cycle tick strobe
//   dir    : walk direction (0 = toward MSB, 1 = toward LSB)
//   in     : synchronised button levels, N bits
//   y      : one-hot target LED
//   win/lose/over : mutually exclusive state flags
//   score/streak  : SCORE_W-bit saturating counters
//   misses        : 4-bit miss counter
interface guess_game_n_if #(
    parameter int N       = 4,
    parameter int SCORE_W = 4
);
    logic               en;
    logic               dir;
    logic [N-1:0]       in;
    logic [N-1:0]       y;
    logic               win;
    logic               lose;
    logic               over;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] streak;
    logic [3:0]         misses;

    modport master (
        output en, dir, in,
        input  y, win, lose, over, score, streak, misses
    );

    modport slave (
        input  en, dir, in,
        output y, win, lose, over, score, streak, misses
    );
endinterface

// File: rtl/guess_game_n.sv
// guess_game_n: N-position LED guessing game.
// A one-hot target walks across N LEDs on each en tick; a press that matches
// the lit LED exactly is a win, any other nonzero press is a loss. Wins,
// streak and misses are counted; MAX_MISS losses lock the game in OVER until
// reset.
//
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : guess_game_n_if.slave (en, dir, in -> y, win, lose, over,
//         score, streak, misses)
//
// Optional build macro GUESS_LFSR_EN: the target hops pseudo-randomly, driven
// by a free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), never landing on
// the same position twice in a row; dir is ignored in that build.
//
// state | meaning
// PLAY  | target walking, waiting for a press
// WIN   | correct press seen, waiting for all buttons released
// LOSE  | wrong press seen, waiting for all buttons released
// OVER  | MAX_MISS losses reached, frozen until reset
module guess_game_n #(
    parameter int N        = 4,
    parameter int SCORE_W  = 4,
    parameter int MAX_MISS = 3
) (
    input  logic           clk,
    input  logic           rst,
    guess_game_n_if.slave  bus
);
    localparam int POS_W = $clog2(N);

    localparam logic [1:0] S_PLAY = 2'd0;
    localparam logic [1:0] S_WIN  = 2'd1;
    localparam logic [1:0] S_LOSE = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [POS_W-1:0]   pos_q,    pos_d;
    logic [N-1:0]       y_q,      y_d;
    logic               win_q,    win_d;
    logic               lose_q,   lose_d;
    logic               over_q,   over_d;
    logic [SCORE_W-1:0] score_q,  score_d;
    logic [SCORE_W-1:0] streak_q, streak_d;
    logic [3:0]         misses_q, misses_d;
    logic [POS_W-1:0]   pos_next;

`ifdef GUESS_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] hop;
    logic [7:0] sum;
    logic       unused_dir;

    assign unused_dir = bus.dir;

    // hop is 0..N-2, so pos + 1 + hop (mod N) can never equal pos.
    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        hop      = lfsr_q % 8'(N - 1);
        sum      = 8'(pos_q) + 8'd1 + hop;
        pos_next = POS_W'(sum % 8'(N));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 8'h01;
        else     lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        if (bus.dir)
            pos_next = (pos_q == '0) ? POS_W'(N - 1) : pos_q - POS_W'(1);
        else
            pos_next = (pos_q == POS_W'(N - 1)) ? '0 : pos_q + POS_W'(1);
    end
`endif

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        score_d  = score_q;
        streak_d = streak_q;
        misses_d = misses_q;

        if (bus.en) begin
            case (state_q)
                S_PLAY: begin
                    if (bus.in == '0) begin
                        pos_d = pos_next;
                    end else if (bus.in == y_q) begin
                        // y_q is one-hot, so equality also rules out multi-press
                        state_d = S_WIN;
                        if (score_q != {SCORE_W{1'b1}})
                            score_d = score_q + SCORE_W'(1);
                        if (streak_q != {SCORE_W{1'b1}})
                            streak_d = streak_q + SCORE_W'(1);
                    end else begin
                        streak_d = '0;
                        if (misses_q < 4'(MAX_MISS))
                            misses_d = misses_q + 4'd1;
                        state_d = (misses_d == 4'(MAX_MISS)) ? S_OVER : S_LOSE;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (bus.in == '0) begin
                        state_d = S_PLAY;
                        pos_d   = '0;
                    end
                end
                S_OVER: begin
                end
                default: begin
                    state_d = S_PLAY;
                    pos_d   = '0;
                end
            endcase
        end

        y_d    = {{(N - 1){1'b0}}, 1'b1} << pos_d;
        win_d  = (state_d == S_WIN);
        lose_d = (state_d == S_LOSE);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_PLAY;
            pos_q    <= '0;
            y_q      <= {{(N - 1){1'b0}}, 1'b1};
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            over_q   <= 1'b0;
            score_q  <= '0;
            streak_q <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            y_q      <= y_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            over_q   <= over_d;
            score_q  <= score_d;
            streak_q <= streak_d;
            misses_q <= misses_d;
        end
    end

    assign bus.y      = y_q;
    assign bus.win    = win_q;
    assign bus.lose   = lose_q;
    assign bus.over   = over_q;
    assign bus.score  = score_q;
    assign bus.streak = streak_q;
    assign bus.misses = misses_q;
endmodule

// File: tb/tb_guess_game_n.sv
// tb_guess_game_n: directed and randomised checks of guess_game_n against a
// behavioural game model (position index, mode, plain integer counters).
module tb_guess_game_n;
    localparam int N    = 4;
    localparam int SW   = 2;
    localparam int MM   = 3;
    localparam int SMAX = (1 << SW) - 1;

    localparam int M_PLAY = 0;
    localparam int M_WIN  = 1;
    localparam int M_LOSE = 2;
    localparam int M_OVER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   clk_cnt;

    int m_mode, m_pos, m_score, m_streak, m_misses;

    guess_game_n_if #(.N(N), .SCORE_W(SW)) bus ();

    guess_game_n #(.N(N), .SCORE_W(SW), .MAX_MISS(MM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // clk edges since reset release; the LFSR build uses it to know the
    // generator value at each advance
    always @(posedge clk or posedge rst) begin
        if (rst) clk_cnt <= 0;
        else     clk_cnt <= clk_cnt + 1;
    end

    function automatic int lfsr_after(int k);
        int v;
        v = 1;
        for (int s = 0; s < k; s++)
            v = (v & 1) ? ((v >> 1) ^ 'hB8) : (v >> 1);
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".y"},      32'(bus.y),      32'(1) << m_pos);
        chk({tag, ".win"},    32'(bus.win),    32'(m_mode == M_WIN));
        chk({tag, ".lose"},   32'(bus.lose),   32'(m_mode == M_LOSE));
        chk({tag, ".over"},   32'(bus.over),   32'(m_mode == M_OVER));
        chk({tag, ".score"},  32'(bus.score),  32'(m_score));
        chk({tag, ".streak"}, 32'(bus.streak), 32'(m_streak));
        chk({tag, ".misses"}, 32'(bus.misses), 32'(m_misses));
    endtask

    task automatic model_reset();
        m_mode = M_PLAY; m_pos = 0; m_score = 0; m_streak = 0; m_misses = 0;
    endtask

    task automatic model_tick(bit e, bit d, int i);
        if (!e || m_mode == M_OVER) return;
        if (m_mode == M_PLAY) begin
            if (i == 0) begin
`ifdef GUESS_LFSR_EN
                m_pos = (m_pos + 1 + (lfsr_after(clk_cnt) % (N - 1))) % N;
`else
                m_pos = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
`endif
            end else if (i == (1 << m_pos)) begin
                m_mode   = M_WIN;
                m_score  = (m_score  < SMAX) ? m_score  + 1 : SMAX;
                m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
            end else begin
                m_streak = 0;
                if (m_misses < MM) m_misses++;
                m_mode = (m_misses == MM) ? M_OVER : M_LOSE;
            end
        end else if (i == 0) begin
            m_mode = M_PLAY;
            m_pos  = 0;
        end
    endtask

    // called at posedge+1; drives inputs, lets one edge pass, checks at posedge+1
    task automatic tick(string tag, bit e, bit d, int i);
        bus.en  = e;
        bus.dir = d;
        bus.in  = N'(i);
        model_tick(e, d, i);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        bus.en = 1'b0;
        bus.in = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [N-1:0] pr;
        bus.en = 1'b0; bus.dir = 1'b0; bus.in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // walk and wrap
        for (int k = 0; k < 5; k++) tick("walk_up", 1, 0, 0);
        tick("walk_dn", 1, 1, 0);
        tick("walk_dn", 1, 1, 0);
        tick("idle", 0, 0, 4'b1111);
        tick("idle", 0, 1, 0);

        // correct press, hold, release
        do_reset("rst1");
        tick("to_0100", 1, 0, 0);
        tick("to_0100", 1, 0, 0);
        tick("win", 1, 0, 1 << m_pos);
        for (int k = 0; k < 3; k++) tick("win_hold", 1, 0, 1 << 2);
        tick("win_release", 1, 0, 0);

        // multi-press including the lit bit is a loss
        tick("to_0010", 1, 0, 0);
        tick("multi", 1, 0, 4'b0011);
        tick("lose_release", 1, 0, 0);

        // two more misses -> OVER, then activity is ignored
        tick("miss2", 1, 0, 4'b1000);
        tick("rel2", 1, 0, 0);
        tick("miss3", 1, 0, 4'b0100);
        tick("over_hold", 1, 0, 4'b1111);
        tick("over_hold", 1, 1, 0);
        tick("over_hold", 1, 0, 1 << m_pos);
        tick("over_hold", 0, 0, 0);
        do_reset("rst_over");

        // saturation with 2-bit score
        for (int k = 0; k < 5; k++) begin
            tick("sat_adv", 1, 0, 0);
            tick("sat_win", 1, 0, 1 << m_pos);
            tick("sat_rel", 1, 0, 0);
        end
        tick("sat_loss", 1, 0, 4'b0110);
        tick("sat_rel2", 1, 0, 0);

        // async reset mid-WIN with en low
        tick("pre_win", 1, 0, 1 << m_pos);
        do_reset("async_win");

`ifdef GUESS_LFSR_EN
        pr = bus.y;
        for (int k = 0; k < 20; k++) begin
            tick("lfsr_adv", 1, 1'($urandom), 0);
            chk("lfsr_norepeat", 32'(bus.y != pr), 32'd1);
            pr = bus.y;
        end
`endif

        // randomised play
        for (int k = 0; k < 400; k++) begin
            if (m_mode == M_OVER && $urandom_range(0, 3) == 0) begin
                do_reset("rand_rst");
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)      r = 0;
                else if (r < 7) r = 1 << m_pos;
                else begin
                    pr = N'($urandom);
                    if (pr == '0) pr = 1;
                    r = int'(pr);
                end
                tick("rand", ($urandom_range(0, 9) < 7), 1'($urandom), r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
